// File: rtl/elm_pkg.sv
// elm_pkg: shared Q-format defaults, saturation limits and saturating helpers for the ELM layers.
package elm_pkg;
  localparam int DATA_W = 16;
  localparam int INT_W  = 4;
  localparam int FRAC_W = DATA_W - INT_W;
  localparam int MAX_W  = 64;
  localparam logic signed [DATA_W-1:0]   DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0]   DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [2*DATA_W-1:0] ACC_MAX  = {1'b0, {(2*DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] ACC_MIN  = {1'b1, {(2*DATA_W-1){1'b0}}};
  typedef logic signed [MAX_W-1:0] wide_t;
  // Clamp a sign-extended value into the w-bit signed range; w must stay below MAX_W-1.
  function automatic wide_t sat_narrow(input wide_t x, input int unsigned w);
    wide_t hi, lo;
    hi = wide_t'({1'b0, {(MAX_W-1){1'b1}}} >> (MAX_W - w));
    lo = ~hi;
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    return sat_narrow(a + b, w);
  endfunction
endpackage

// File: rtl/elm_sat_shift.sv
// elm_sat_shift: bias add, rescale by fracBits, narrow-saturate and optional ReLU (macro NEURON_RELU_EN).
module elm_sat_shift
  import elm_pkg::*;
#(
  parameter int dataWidth = DATA_W,
  parameter int fracBits  = FRAC_W
) (
  input  logic signed [2*dataWidth-1:0] acc,
  input  logic signed [2*dataWidth-1:0] bias,
  output logic signed [dataWidth-1:0]   result
);
  logic signed [dataWidth-1:0] narrow;
  always_comb begin
    narrow = dataWidth'(sat_narrow(sat_add(wide_t'(acc), wide_t'(bias), 2*dataWidth) >>> fracBits, dataWidth));
`ifdef NEURON_RELU_EN
    result = narrow[dataWidth-1] ? '0 : narrow;
`else
    result = narrow;
`endif
  end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate neuron driving its weight memory; ReLU via NEURON_RELU_EN.
module neuron_mac
  import elm_pkg::*;
#(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10,
  parameter int numWeight    = 784,
  parameter int intWidth     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [dataWidth-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          w_ren,
  output logic [addressWidth:0]         w_raddr,
  input  logic signed [dataWidth-1:0]   w_data,
  input  logic signed [2*dataWidth-1:0] bias,
  output logic signed [dataWidth-1:0]   out_data,
  output logic                          out_valid
);
  localparam int fracBits = dataWidth - intWidth;
  localparam logic [addressWidth:0] LAST = (addressWidth+1)'(numWeight - 1);
  logic                          v1, f1, l1, v2, f2, l2, l3;
  logic signed [dataWidth-1:0]   d1, res;
  logic signed [2*dataWidth-1:0] prod, acc;
  assign w_ren = in_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_raddr <= '0;
    end else if (in_valid) begin
      w_raddr <= (w_raddr == LAST) ? '0 : w_raddr + (addressWidth+1)'(1);
    end
  end
  // Stages 1-3: align sample with the returned weight, multiply, then load or accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      f1   <= 1'b0;
      l1   <= 1'b0;
      d1   <= '0;
      v2   <= 1'b0;
      f2   <= 1'b0;
      l2   <= 1'b0;
      prod <= '0;
      acc  <= '0;
      l3   <= 1'b0;
    end else begin
      v1 <= in_valid;
      f1 <= in_valid && w_raddr == '0;
      l1 <= in_valid && w_raddr == LAST;
      if (in_valid) d1 <= in_data;
      v2 <= v1;
      f2 <= v1 && f1;
      l2 <= v1 && l1;
      if (v1) prod <= d1 * w_data;
      if (v2) acc <= f2 ? prod : (2*dataWidth)'(sat_add(wide_t'(acc), wide_t'(prod), 2*dataWidth));
      l3 <= v2 && l2;
    end
  end
  elm_sat_shift #(.dataWidth(dataWidth), .fracBits(fracBits)) u_sat_shift (
    .acc(acc),
    .bias(bias),
    .result(res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= l3;
      if (l3) out_data <= res;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed and randomized frames checked against a plain-arithmetic neuron model.
module tb_neuron_mac;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NW = 4;
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 w_ren;
  logic [AW:0]          w_raddr;
  logic signed [DW-1:0] w_data = '0;
  logic signed [2*DW-1:0] bias = '0;
  logic [DW-1:0]        out_data;
  logic                 out_valid;
  logic signed [DW-1:0] wmem [NW];
  logic signed [DW-1:0] a [NW];
  logic [DW-1:0]        exp_q [$];
  int                   lat_q [$];
  int                   checks = 0, errors = 0, cyc = 0, frames = 0, pulses = 0;
  neuron_mac #(.dataWidth(DW), .addressWidth(AW), .numWeight(NW), .intWidth(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .w_ren(w_ren),
    .w_raddr(w_raddr), .w_data(w_data), .bias(bias), .out_data(out_data), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (w_ren) w_data <= wmem[w_raddr[1:0]];
  task automatic check(input string tag, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask
  function automatic longint clamp(input longint v, input int w);
    longint mx = (longint'(1) << (w - 1)) - 1;
    return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
  endfunction
  function automatic logic [DW-1:0] model(input logic signed [DW-1:0] x [NW], input logic signed [2*DW-1:0] b);
    longint s = 0;
    for (int i = 0; i < NW; i++) s = clamp(s + longint'(x[i]) * longint'(wmem[i]), 2*DW);
    s = clamp(clamp(s + longint'(b), 2*DW) >>> 12, DW);
`ifdef NEURON_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[DW-1:0];
  endfunction
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      pulses++;
      if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        check("out_data", out_data, exp_q.pop_front());
        check("latency", cyc - lat_q.pop_front(), 4);
      end
    end
  end
  task automatic send_frame(input logic signed [DW-1:0] x [NW], input int n, input int gap, input logic [DW-1:0] expv);
    for (int i = 0; i < n; i++) begin
      int g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 check("w_ren_idle", w_ren, 0);
      end
      @(posedge clk);
      #1 in_valid = 1'b1;
      in_data = x[i];
      #1 check("w_ren", w_ren, 1);
      check("w_raddr", w_raddr, i);
    end
    if (n == NW) begin
      exp_q.push_back(expv);
      lat_q.push_back(cyc);
      frames++;
    end
  endtask
  task automatic drain();
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_timeout", exp_q.size(), 0);
  endtask
  task automatic fill(input logic signed [DW-1:0] w, input logic signed [DW-1:0] v);
    for (int i = 0; i < NW; i++) begin
      wmem[i] = w;
      a[i] = v;
    end
  endtask
  initial begin
    fill(16'sh1000, 16'sh0);
    repeat (2) @(posedge clk);
    #1 check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_w_raddr", w_raddr, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < NW; i++) a[i] = DW'((i + 1) * 16'h1000);
    send_frame(a, NW, 0, 16'h7FFF);
    drain();
    check("hold_valid", out_valid, 0);
    check("hold_data", out_data, 16'h7FFF);
    fill(16'sh1000, 16'sh0800);
    bias = 32'sh0100_0000;
    send_frame(a, NW, 0, 16'h3000);
    drain();
    send_frame(a, NW, 1, 16'h3000);
    drain();
    send_frame(a, NW, 0, 16'h3000);
    fill(16'sh1000, 16'sh0);
    send_frame(a, NW, 0, 16'h1000);
    drain();
    fill(-16'sh1000, 16'sh1000);
    bias = '0;
`ifdef NEURON_RELU_EN
    send_frame(a, NW, 0, 16'h0000);
`else
    send_frame(a, NW, 0, 16'hC000);
`endif
    drain();
    fill(16'sh1000, 16'sh1000);
    send_frame(a, 2, 0, 16'h0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("mid_rst_out_data", out_data, 0);
    check("mid_rst_w_raddr", w_raddr, 0);
    repeat (3) @(posedge clk);
    #1 check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    fill(16'sh1000, 16'sh0800);
    bias = 32'sh0100_0000;
    send_frame(a, NW, 0, 16'h3000);
    drain();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NW; i++) wmem[i] = DW'($urandom);
      bias = b[0] ? 2*DW'($urandom) : 2*DW'(int'($urandom_range(0, 1 << 26)) - (1 << 25));
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < NW; i++) a[i] = b[1] ? DW'($urandom) : DW'(int'($urandom_range(0, 8191)) - 4096);
        send_frame(a, NW, -1, model(a, bias));
      end
      drain();
    end
    check("pulse_count", pulses, frames);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Single-neuron compute stage directly downstream of a layer's weight memory.
- Consumes a stream of activations from the previous layer and drives the weight memory's `ren`/`raddr`.
- Multiplies each activation by the returned weight, accumulates a full frame, adds bias, rescales, saturates, optionally applies ReLU, and emits one neuron output per frame.
- One instance per neuron; the layer wrapper instantiates N of them alongside N weight memories.

Parameters:
- `dataWidth`, 16: activation/weight/output width, signed two's complement.
- `addressWidth`, 10: weight memory address width; `raddr` is `addressWidth+1` bits to match the weight memory port.
- `numWeight`, 784: activations per frame; legal range 1..2^addressWidth.
- `intWidth`, 4: integer bits of the Q format; fracBits = `dataWidth-intWidth`.

Ports:
- `clk`  in  1  clock, all logic on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_data`  in  `dataWidth`  activation sample
- `in_valid`  in  1  `in_data` valid this cycle; no backpressure, any gap pattern allowed
- `w_ren`  out  1  weight memory read enable
- `w_raddr`  out  `addressWidth+1`  weight memory read address
- `w_data`  in  `dataWidth`  weight memory read data, valid 1 cycle after `w_ren`
- `bias`  in  `2*dataWidth`  bias already aligned to the product format (2*fracBits fractional bits), static per frame
- `out_data`  out  `dataWidth`  neuron output
- `out_valid`  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset, async assert, sync deassert upstream:
  - `out_data`=0, `out_valid`=0, `w_raddr`=0, all pipeline valids=0, accumulator=0, element counter=0.
  - Reset mid-frame discards the partial sum; the next `in_valid` is element 0.
- Address generation:
  - `w_ren` = `in_valid` (combinational).
  - `w_raddr` = registered counter, presented in the same cycle as `in_valid`.
  - Counter increments on each `in_valid`; wraps to 0 after `numWeight-1`.
- Stage 1, cycle t+1: register `in_data`, `valid`, first flag (cnt==0) and last flag (cnt==`numWeight-1`) so they align with `w_data`.
- Stage 2, t+2: product register = signed `in_d1` × `w_data`, `2*dataWidth` bits; flags delayed alongside.
- Stage 3, t+3, accumulate into a `2*dataWidth` signed register:
  - If first flag: acc <= product (load, no clear cycle needed).
  - Otherwise: acc <= sat(acc + product).
  - Saturation clamps to max/min `2*dataWidth` signed on overflow.
- Stage 4, t+4, when last flag was set at stage 3:
  - sum = sat(acc + bias).
  - Arithmetic right shift by fracBits.
  - Saturate to `dataWidth` signed.
  - Result to `out_data`; `out_valid`=1 for exactly one cycle.
- `out_data` holds its value until the next frame completes.
- Latency: last `in_valid` at cycle t gives `out_valid` at t+4.
- Back-to-back frames with no idle cycle are legal. The first-flag load lets frame k+1 accumulate while frame k's output stage fires.
- `numWeight`=1: first and last flags are both set; result = sat(product+bias).
- No `in_valid` means the pipeline holds; bubbles propagate with valid=0 and the accumulator does not change.

Optional Feature:
- Macro `NEURON_RELU_EN`.
- Defined: stage 4 output is forced to 0 when the saturated result is negative (ReLU).
- Undefined: the signed saturated result passes through unchanged (linear output, used for the ELM output layer).

Decomposition:
- Shared package `elm_pkg`:
  - Saturation limit constants for `dataWidth` and `2*dataWidth`.
  - `sat_add` and `sat_narrow` functions.
  - Default Q-format constants (`DATA_W`, `INT_W`, `FRAC_W`).
- Natural sub-module: `elm_sat_shift`, the stage-4 bias add, shift, narrow-saturate and activation block, reusable by the output layer.
- Address counter and MAC pipeline stay in `neuron_mac`.

Test Plan:
- `numWeight`=4, intWidth=4, all weights 0x1000 (1.0), inputs 1.0, 2.0, 3.0, 4.0 back-to-back, bias 0 -> `w_raddr` 0,1,2,3 with `w_ren`=1; `out_data`=0xA000 saturated to 0x7FFF; `out_valid` exactly 4 cycles after the last `in_valid`.
- Same with inputs 0.5 ×4 (0x0800), bias = 1.0 aligned (0x01000000) -> `out_data`=0x3000 (3.0).
- Gapped input: `in_valid` on alternate cycles, same as previous -> identical result; `w_raddr` advances only on valid cycles; single `out_valid` pulse.
- Two frames back-to-back with zero gap, second frame all zeros -> frame 1 = 0x3000, frame 2 = bias-only 0x1000; no cross-frame leakage.
- Negative result (weights -1.0, inputs 1.0 ×4, bias 0):
  - `NEURON_RELU_EN` undefined -> 0xC000.
  - `NEURON_RELU_EN` defined -> 0x0000.
- `rst_n` asserted after 2 of 4 inputs, then a full frame of 0.5 ×4 with bias 1.0 -> outputs 0 during reset, `w_raddr` restarts at 0, result 0x3000 with no residue.
